// File: rtl/board_render_pkg.sv
// ============================================================================
// Module      : board_render_pkg
// Description : Shared constants, FSM state encoding and width helper for the
//               checkers-board renderer. Optional macro: WIN_BANNER_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package board_render_pkg;

    localparam logic [2:0] CODE_EMPTY      = 3'b000;
    localparam logic [2:0] CODE_DARK_MAN   = 3'b001;
    localparam logic [2:0] CODE_LIGHT_MAN  = 3'b010;
    localparam logic [2:0] CODE_DARK_KING  = 3'b011;
    localparam logic [2:0] CODE_LIGHT_KING = 3'b100;

    localparam logic [2:0] CLR_P1    = 3'b000;
    localparam logic [2:0] CLR_SEL   = 3'b001;
    localparam logic [2:0] CLR_HL    = 3'b010;
    localparam logic [2:0] CLR_P2    = 3'b100;
    localparam logic [2:0] CLR_KING  = 3'b101;
    localparam logic [2:0] CLR_DARK  = 3'b110;
    localparam logic [2:0] CLR_LIGHT = 3'b111;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_TILES  = 3'd1,
        ST_PIECES = 3'd2,
        ST_FINISH = 3'd3
`ifdef WIN_BANNER_EN
        , ST_BANNER = 3'd4
`endif
    } state_t;

    // Never returns less than 1 so a one-entry range still gets a real bit.
    function automatic int clog2(input int value);
        int w;
        w = 1;
        while ((1 << w) < value) w = w + 1;
        return w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/piece_sprite_rom.sv
// ============================================================================
// Module      : piece_sprite_rom
// Description : Combinational disc sprite: sprite row -> horizontal span
//               [lo,hi]; rows outside the disc return lo > hi.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module piece_sprite_rom
    import board_render_pkg::*;
#(
    parameter int CELL = 15
) (
    input  logic [clog2(CELL)-1:0] sr,
    output logic [clog2(CELL)-1:0] lo,
    output logic [clog2(CELL)-1:0] hi
);

    localparam int SW  = clog2(CELL);
    localparam int CTR = CELL / 2;
    localparam int RAD = CELL / 2 - 1;

    int dy;
    int rem;
    int half;

    // Half-width is the integer square root of RAD^2 - dy^2.
    always_comb begin
        dy = int'(sr) - CTR;
        if (dy < 0) dy = -dy;
        rem  = RAD * RAD - dy * dy;
        half = 0;
        for (int k = 0; k <= RAD; k++) begin
            if (k * k <= rem) half = k;
        end
        if (dy <= RAD) begin
            lo = SW'(CTR - half);
            hi = SW'(CTR + half);
        end else begin
            lo = SW'(1);
            hi = '0;
        end
    end

endmodule

`default_nettype wire

// File: rtl/board_renderer.sv
// ============================================================================
// Module      : board_renderer
// Description : Streams a checkers board (tiles, overlays, sprite pieces) one
//               pixel per clock. Optional macro: WIN_BANNER_EN (win banner).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module board_renderer
    import board_render_pkg::*;
#(
    parameter int BOARD_N  = 8,
    parameter int CELL     = 15,
    parameter int ORIGIN_X = 20,
    parameter int ORIGIN_Y = 0,
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int CLR_W    = 3
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           redraw,
    input  logic [3*BOARD_N*BOARD_N-1:0]   board,
    input  logic [clog2(BOARD_N)-1:0]      sel_x,
    input  logic [clog2(BOARD_N)-1:0]      sel_y,
    input  logic [clog2(BOARD_N)-1:0]      hl_x,
    input  logic [clog2(BOARD_N)-1:0]      hl_y,
    input  logic                           hl_en,
`ifdef WIN_BANNER_EN
    input  logic                           win,
    input  logic                           p1_win,
`endif
    output logic [X_W-1:0]                 x,
    output logic [Y_W-1:0]                 y,
    output logic [CLR_W-1:0]               colour,
    output logic                           plot,
    output logic                           busy,
    output logic                           done
);

    localparam int CW    = clog2(BOARD_N);
    localparam int SW    = clog2(CELL);
    localparam int NCELL = BOARD_N * BOARD_N;
    localparam int IW    = clog2(NCELL);
    localparam int BW    = BOARD_N * CELL;
    localparam logic [CW-1:0] LAST_CELL = CW'(BOARD_N - 1);
    localparam logic [SW-1:0] LAST_SUB  = SW'(CELL - 1);
    localparam logic [SW-1:0] KING_ROW  = SW'(CELL / 2);

    state_t                     state, state_n;
    logic [CW-1:0]              col, col_n, row, row_n;
    logic [SW-1:0]              sx, sx_n, sy, sy_n;
    logic                       row_start, row_start_n;
    logic                       pending, pending_n;
    logic                       snap;
    logic [3*NCELL-1:0]         board_s;
    logic [CW-1:0]              sel_x_s, sel_y_s, hl_x_s, hl_y_s;
    logic                       hl_en_s;
    logic [X_W-1:0]             x_n;
    logic [Y_W-1:0]             y_n;
    logic [CLR_W-1:0]           colour_n;
    logic                       plot_n, busy_n, done_n;
    logic [2:0]                 cells [NCELL];
    logic [2:0]                 code;
    logic [2:0]                 tile_clr, piece_clr;
    logic                       is_piece;
    logic [SW-1:0]              span_lo, span_hi, eff_sc;
    logic                       adv_row, adv_cell;
    logic [31:0]                bx, by;
    state_t                     after_pieces;
`ifdef WIN_BANNER_EN
    localparam int BCW = clog2(4 * BW);
    localparam logic [BCW-1:0] BLAST = BCW'(4 * BW - 5);
    logic                       win_s, p1_win_s;
    logic [BCW-1:0]             bcnt, bcnt_n;
    logic [31:0]                k;
`endif

    for (genvar i = 0; i < NCELL; i++) begin : g_cells
        assign cells[i] = board_s[3*i +: 3];
    end

    piece_sprite_rom #(.CELL(CELL)) u_rom (
        .sr (sy),
        .lo (span_lo),
        .hi (span_hi)
    );

    // Overlay priority: highlight, then selected row/column, then checker base.
    always_comb begin
        code = cells[IW'(32'(row) * BOARD_N + 32'(col))];
        is_piece = (code == CODE_DARK_MAN) || (code == CODE_LIGHT_MAN) ||
                   (code == CODE_DARK_KING) || (code == CODE_LIGHT_KING);
        if (hl_en_s && col == hl_x_s && row == hl_y_s)  tile_clr = CLR_HL;
        else if (col == sel_x_s || row == sel_y_s)       tile_clr = CLR_SEL;
        else if (col[0] ^ row[0])                        tile_clr = CLR_DARK;
        else                                             tile_clr = CLR_LIGHT;
        if ((code == CODE_DARK_KING || code == CODE_LIGHT_KING) && sy > KING_ROW)
            piece_clr = CLR_KING;
        else if (code == CODE_LIGHT_MAN || code == CODE_LIGHT_KING)
            piece_clr = CLR_P2;
        else
            piece_clr = CLR_P1;
`ifdef WIN_BANNER_EN
        after_pieces = win_s ? ST_BANNER : ST_FINISH;
`else
        after_pieces = ST_FINISH;
`endif
    end

    always_comb begin
        state_n     = state;
        col_n       = col;
        row_n       = row;
        sx_n        = sx;
        sy_n        = sy;
        row_start_n = row_start;
        pending_n   = pending | (redraw && state != ST_IDLE);
        snap        = 1'b0;
        x_n         = x;
        y_n         = y;
        colour_n    = colour;
        plot_n      = 1'b0;
        busy_n      = busy;
        done_n      = 1'b0;
        bx          = '0;
        by          = '0;
        eff_sc      = row_start ? span_lo : sx;
        adv_row     = 1'b0;
        adv_cell    = 1'b0;
`ifdef WIN_BANNER_EN
        bcnt_n      = bcnt;
        k           = 32'(bcnt);
`endif
        case (state)
            ST_IDLE: begin
                if (redraw || pending) begin
                    snap      = 1'b1;
                    pending_n = 1'b0;
                    busy_n    = 1'b1;
                    col_n     = '0;
                    row_n     = '0;
                    sx_n      = '0;
                    sy_n      = '0;
                    state_n   = ST_TILES;
                end
            end
            ST_TILES: begin
                bx       = 32'(col) * CELL + 32'(sx);
                by       = 32'(row) * CELL + 32'(sy);
                plot_n   = 1'b1;
                colour_n = CLR_W'(tile_clr);
                if (sx == LAST_SUB) begin
                    sx_n = '0;
                    if (col == LAST_CELL) begin
                        col_n = '0;
                        if (sy == LAST_SUB) begin
                            sy_n = '0;
                            if (row == LAST_CELL) begin
                                row_n       = '0;
                                row_start_n = 1'b1;
                                state_n     = ST_PIECES;
                            end else begin
                                row_n = row + 1'b1;
                            end
                        end else begin
                            sy_n = sy + 1'b1;
                        end
                    end else begin
                        col_n = col + 1'b1;
                    end
                end else begin
                    sx_n = sx + 1'b1;
                end
            end
            ST_PIECES: begin
                bx = 32'(col) * CELL + 32'(eff_sc);
                by = 32'(row) * CELL + 32'(sy);
                if (!is_piece) begin
                    adv_cell = 1'b1;
                end else if (span_lo > span_hi) begin
                    adv_row = 1'b1;
                end else begin
                    plot_n      = 1'b1;
                    colour_n    = CLR_W'(piece_clr);
                    sx_n        = eff_sc + 1'b1;
                    row_start_n = 1'b0;
                    adv_row     = (eff_sc == span_hi);
                end
                if (adv_row) begin
                    if (sy == LAST_SUB) begin
                        adv_cell = 1'b1;
                    end else begin
                        sy_n        = sy + 1'b1;
                        row_start_n = 1'b1;
                    end
                end
                if (adv_cell) begin
                    sy_n        = '0;
                    row_start_n = 1'b1;
                    if (col == LAST_CELL) begin
                        col_n = '0;
                        if (row == LAST_CELL) begin
                            row_n   = '0;
                            state_n = after_pieces;
`ifdef WIN_BANNER_EN
                            bcnt_n  = '0;
`endif
                        end else begin
                            row_n = row + 1'b1;
                        end
                    end else begin
                        col_n = col + 1'b1;
                    end
                end
            end
`ifdef WIN_BANNER_EN
            ST_BANNER: begin
                // Clockwise walk: top edge, right edge, bottom edge, left edge.
                if (k < 32'(BW)) begin
                    bx = k;
                    by = '0;
                end else if (k < 32'(2 * BW - 1)) begin
                    bx = 32'(BW - 1);
                    by = k - 32'(BW - 1);
                end else if (k < 32'(3 * BW - 2)) begin
                    bx = 32'(3 * BW - 3) - k;
                    by = 32'(BW - 1);
                end else begin
                    bx = '0;
                    by = 32'(4 * BW - 4) - k;
                end
                plot_n   = 1'b1;
                colour_n = CLR_W'(p1_win_s ? CLR_P1 : CLR_P2);
                if (bcnt == BLAST) state_n = ST_FINISH;
                else               bcnt_n  = bcnt + 1'b1;
            end
`endif
            ST_FINISH: begin
                done_n  = 1'b1;
                busy_n  = 1'b0;
                state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
                busy_n  = 1'b0;
            end
        endcase
        if (plot_n) begin
            x_n = X_W'(32'(ORIGIN_X) + bx);
            y_n = Y_W'(32'(ORIGIN_Y) + by);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            col       <= '0;
            row       <= '0;
            sx        <= '0;
            sy        <= '0;
            row_start <= 1'b0;
            pending   <= 1'b0;
            board_s   <= '0;
            sel_x_s   <= '0;
            sel_y_s   <= '0;
            hl_x_s    <= '0;
            hl_y_s    <= '0;
            hl_en_s   <= 1'b0;
            x         <= '0;
            y         <= '0;
            colour    <= '0;
            plot      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
`ifdef WIN_BANNER_EN
            win_s     <= 1'b0;
            p1_win_s  <= 1'b0;
            bcnt      <= '0;
`endif
        end else begin
            state     <= state_n;
            col       <= col_n;
            row       <= row_n;
            sx        <= sx_n;
            sy        <= sy_n;
            row_start <= row_start_n;
            pending   <= pending_n;
            x         <= x_n;
            y         <= y_n;
            colour    <= colour_n;
            plot      <= plot_n;
            busy      <= busy_n;
            done      <= done_n;
            if (snap) begin
                board_s <= board;
                sel_x_s <= sel_x;
                sel_y_s <= sel_y;
                hl_x_s  <= hl_x;
                hl_y_s  <= hl_y;
                hl_en_s <= hl_en;
`ifdef WIN_BANNER_EN
                win_s    <= win;
                p1_win_s <= p1_win;
`endif
            end
`ifdef WIN_BANNER_EN
            bcnt <= bcnt_n;
`endif
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_board_renderer.sv
// ============================================================================
// Module      : tb_board_renderer
// Description : Directed self-checking bench for board_renderer (8x8, 15 px).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_board_renderer;

    localparam int BW = 120;

    logic         clk = 1'b0;
    logic         reset;
    logic         redraw;
    logic [191:0] board;
    logic [2:0]   sel_x, sel_y, hl_x, hl_y;
    logic         hl_en;
`ifdef WIN_BANNER_EN
    logic         win, p1_win;
`endif
    logic [7:0]   x;
    logic [6:0]   y;
    logic [2:0]   colour;
    logic         plot, busy, done;

    always #5 clk = ~clk;

    board_renderer dut (
        .clk    (clk),
        .reset  (reset),
        .redraw (redraw),
        .board  (board),
        .sel_x  (sel_x),
        .sel_y  (sel_y),
        .hl_x   (hl_x),
        .hl_y   (hl_y),
        .hl_en  (hl_en),
`ifdef WIN_BANNER_EN
        .win    (win),
        .p1_win (p1_win),
`endif
        .x      (x),
        .y      (y),
        .colour (colour),
        .plot   (plot),
        .busy   (busy),
        .done   (done)
    );

    int n_checks = 0;
    int n_bad    = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    logic [2:0] tile_img [0:255][0:127];
    logic [2:0] pc_img   [0:255][0:127];
    bit         pc_hit   [0:255][0:127];
    int         tiles_n, pc_n, post_cyc, tile_span;
    int         first_x, first_y, first_c;
    bit         got_done, busy_at_done;

    task automatic pulse_redraw();
        @(negedge clk) redraw = 1'b1;
        @(negedge clk) redraw = 1'b0;
    endtask

    // First BW*BW plots are tile pixels, later ones piece/banner pixels.
    task automatic run_frame(input string tag);
        int cyc, first_cyc, last_tile_cyc;
        for (int i = 0; i < 256; i++)
            for (int j = 0; j < 128; j++) pc_hit[i][j] = 1'b0;
        tiles_n = 0; pc_n = 0; got_done = 1'b0; post_cyc = 0; tile_span = 0;
        cyc = 0; first_cyc = 0; last_tile_cyc = 0;
        while (!got_done && cyc < 40000) begin
            @(negedge clk);
            cyc++;
            if (plot === 1'b1) begin
                if (tiles_n < BW * BW) begin
                    if (tiles_n == 0) begin
                        first_cyc = cyc; first_x = x; first_y = y; first_c = colour;
                    end
                    tile_img[x][y] = colour;
                    tiles_n++;
                    if (tiles_n == BW * BW) last_tile_cyc = cyc;
                end else begin
                    pc_img[x][y] = colour;
                    pc_hit[x][y] = 1'b1;
                    pc_n++;
                end
            end
            if (done === 1'b1) begin
                got_done     = 1'b1;
                busy_at_done = busy;
                post_cyc     = cyc - last_tile_cyc;
                tile_span    = last_tile_cyc - first_cyc + 1;
            end
        end
        check({tag, "_done_seen"}, got_done, 1);
        check({tag, "_busy_at_done"}, busy_at_done, 0);
        @(negedge clk);
        check({tag, "_done_one_cycle"}, done, 0);
    endtask

    task automatic check_empty_frame(input string tag);
        check({tag, "_tile_plots"}, tiles_n, BW * BW);
        check({tag, "_tile_span"}, tile_span, BW * BW);
        check({tag, "_pieces_cycles"}, post_cyc, 65);
        check({tag, "_piece_plots"}, pc_n, 0);
        check({tag, "_first_x"}, first_x, 20);
        check({tag, "_first_y"}, first_y, 0);
    endtask

    initial begin
        int cnt, cyc;
        reset = 1'b1; redraw = 1'b0; board = '0;
        sel_x = 3'd0; sel_y = 3'd0; hl_x = 3'd1; hl_y = 3'd1; hl_en = 1'b0;
`ifdef WIN_BANNER_EN
        win = 1'b0; p1_win = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check("rst_plot", plot, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_xy", {x, 1'b0, y}, 0);
        check("rst_colour", colour, 0);
        reset = 1'b0;
        @(negedge clk);

        // Empty board, sel 0/0, highlight disabled
        pulse_redraw();
        check("t1_busy", busy, 1);
        run_frame("t1");
        check_empty_frame("t1");
        check("t1_first_colour", first_c, 3'b001);
        check("t1_cell11", tile_img[35][15], 3'b111);
        check("t1_cell21", tile_img[50][15], 3'b110);
        check("t1_cell77_last", tile_img[139][119], 3'b111);
        check("t1_cell70_sel", tile_img[125][5], 3'b001);

        // Pieces; board/sel changed after snapshot must not matter
        board = '0;
        board[3*26 +: 3] = 3'b001;
        board[3*0  +: 3] = 3'b100;
        board[3*63 +: 3] = 3'b111;
        board[3*62 +: 3] = 3'b101;
        sel_x = 3'd5; sel_y = 3'd6; hl_x = 3'd5; hl_y = 3'd6; hl_en = 1'b1;
        pulse_redraw();
        board = {64{3'b011}}; sel_x = 3'd0; sel_y = 3'd0; hl_en = 1'b0;
        run_frame("t2");
        check("t2_tile_span", tile_span, BW * BW);
        check("t2_cell00", tile_img[20][0], 3'b111);
        check("t2_selcol", tile_img[95][0], 3'b001);
        check("t2_selrow", tile_img[35][90], 3'b001);
        check("t2_hl", tile_img[98][94], 3'b010);
        check("t2_cell21", tile_img[50][15], 3'b110);
        check("t2_pieces_cycles", post_cyc, 293);
        check("t2_piece_plots", pc_n, 226);
        check("t2_man_centre_hit", pc_hit[57][52], 1);
        check("t2_man_centre", pc_img[57][52], 3'b000);
        check("t2_man_corner", pc_hit[50][45], 0);
        check("t2_king_row10", pc_img[27][10], 3'b101);
        check("t2_king_row8", pc_img[27][8], 3'b101);
        check("t2_king_row7_lo", pc_img[21][7], 3'b100);
        check("t2_king_row7_out", pc_hit[20][7], 0);
        check("t2_king_row3", pc_img[27][3], 3'b100);
        check("t2_king_row1", pc_hit[27][1], 1);
        check("t2_king_row1_side", pc_hit[26][1], 0);

        // Redraw while busy: exactly one extra frame
        board = '0; sel_x = 3'd0; sel_y = 3'd0; hl_en = 1'b0;
        pulse_redraw();
        fork
            run_frame("t4a");
            begin
                repeat (100) @(negedge clk);
                redraw = 1'b1; @(negedge clk); redraw = 1'b0;
                repeat (100) @(negedge clk);
                redraw = 1'b1; @(negedge clk); redraw = 1'b0;
            end
        join
        check_empty_frame("t4a");
        run_frame("t4b");
        check_empty_frame("t4b");
        cnt = 0;
        repeat (30) begin
            @(negedge clk);
            if (busy !== 1'b0 || plot !== 1'b0) cnt++;
        end
        check("t4_idle_after", cnt, 0);

        // Reset in mid-frame
        pulse_redraw();
        cnt = 0; cyc = 0;
        while (cnt < 5000 && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            if (plot === 1'b1) cnt++;
        end
        check("t5_reached_5000", cnt, 5000);
        reset = 1'b1;
        @(negedge clk);
        check("t5_plot_after_rst", plot, 0);
        check("t5_busy_after_rst", busy, 0);
        reset = 1'b0;
        cnt = 0;
        repeat (5) begin
            @(negedge clk);
            if (plot !== 1'b0) cnt++;
        end
        check("t5_no_plot", cnt, 0);
        sel_x = 3'd2; sel_y = 3'd3;
        pulse_redraw();
        cyc = 0;
        while (plot !== 1'b1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("t5_restart_plot", plot, 1);
        check("t5_restart_x", x, 20);
        check("t5_restart_y", y, 0);
        check("t5_restart_colour", colour, 3'b111);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

`ifdef WIN_BANNER_EN
        // Win banner, light player wins
        board = '0; win = 1'b1; p1_win = 1'b0;
        pulse_redraw();
        win = 1'b0; p1_win = 1'b1;
        run_frame("t6");
        check("t6_tile_span", tile_span, BW * BW);
        check("t6_banner_plots", pc_n, 476);
        check("t6_post_cycles", post_cyc, 541);
        check("t6_corner_tl", pc_img[20][0], 3'b100);
        check("t6_corner_br", pc_hit[139][119], 1);
        check("t6_left_edge", pc_img[20][60], 3'b100);
        check("t6_interior", pc_hit[21][1], 0);
`endif

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
